i2c_txn_arbiter: RTL

Round-robin arbiter and sequencer sharing one byte-level I2C master between up to `N_REQ` on-chip requesters. Example requesters: switch poller reading slave 0x57, LED writer, debug port. It sits between the requesters and the I2C master core. For each transaction it:
- latches one single-byte command,
- hands it to the master,
- guards the master with a watchdog,
- returns the result to the granted requester only.

---
 rtl/i2c_txn_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
//   Round-robin arbiter and sequencer that shares one byte-level I2C master
//   between N_REQ requesters. One single-byte command is latched per grant,
//   handed to the master, guarded by a watchdog, and its result is returned
//   only to the granted requester.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/addr/rw/wdata    per-requester command (slices of 7/8 bits)
//   req_ready                  1-cycle pulse: command of requester i latched
//   rsp_valid/rdata/nack/timeout
//                              1-cycle result pulse to the granted requester
//   m_cmd_valid/addr/rw/wdata  command to the master, held until m_cmd_ready
//   m_cmd_ready                master accepts command
//   m_done/m_rdata/m_nack      master completion pulse and result
//   m_abort                    1-cycle pulse: master must return to idle
//   busy                       high outside IDLE
//   grant_id                   current / last granted requester
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 m_cmd_valid,
    output logic [6:0]           m_cmd_addr,
    output logic                 m_cmd_rw,
    output logic [7:0]           m_cmd_wdata,
    input  logic                 m_cmd_ready,
    input  logic                 m_done,
    input  logic [7:0]           m_rdata,
    input  logic                 m_nack,
    output logic                 m_abort,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam logic [17:0] TERM = 18'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [17:0] r_cnt;

    logic             w_found;
    logic [1:0]       w_win;
    logic [6:0]       w_addr;
    logic             w_rw;
    logic [7:0]       w_wdata;
    logic             w_active;
    logic             w_done_ok;
    logic [N_REQ-1:0] w_gnt_oh;

    // Round robin: scan distances 1..N_REQ from the last served index, the
    // first requester found wins. Constant indices keep the mux static.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_addr  = '0;
        w_rw    = 1'b0;
        w_wdata = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && req_valid[i] && (i == (int'(r_ptr) + k) % N_REQ)) begin
                    w_found = 1'b1;
                    w_win   = 2'(i);
                    w_addr  = req_addr[7*i +: 7];
                    w_rw    = req_rw[i];
                    w_wdata = req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_done_ok = (r_state == S_WAIT) && m_done;
    assign w_gnt_oh  = N_REQ'(1) << grant_id;

    // Abort is decoded combinationally so it lands in the terminal-count
    // cycle itself and can be suppressed by an m_done arriving in that cycle.
    assign m_abort = w_active && (r_cnt == TERM) && !w_done_ok;
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'(N_REQ - 1);
            r_cnt       <= '0;
            grant_id    <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            m_cmd_valid <= 1'b0;
            m_cmd_addr  <= '0;
            m_cmd_rw    <= 1'b0;
            m_cmd_wdata <= '0;
        end else begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        grant_id    <= w_win;
                        m_cmd_addr  <= w_addr;
                        m_cmd_rw    <= w_rw;
                        m_cmd_wdata <= w_wdata;
                        m_cmd_valid <= 1'b1;
                        req_ready   <= N_REQ'(1) << w_win;
                        r_cnt       <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 18'd1;
                    // m_done here is spurious and deliberately ignored
                    if (m_abort) begin
                        m_cmd_valid <= 1'b0;
                        rsp_valid   <= w_gnt_oh;
                        rsp_timeout <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (m_cmd_ready) begin
                        m_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 18'd1;
                    if (m_done) begin
                        rsp_valid <= w_gnt_oh;
                        rsp_rdata <= m_cmd_rw ? m_rdata : 8'h00;
                        rsp_nack  <= m_nack;
                        r_state   <= S_RESP;
                    end else if (m_abort) begin
                        rsp_valid   <= w_gnt_oh;
                        rsp_timeout <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ptr   <= grant_id;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
